// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 execution datapath: operand select codes and
// the bit positions of the active-low load enables.
package td4_pkg;

  typedef enum logic [1:0] {
    SEL_A    = 2'b00,
    SEL_B    = 2'b01,
    SEL_IN   = 2'b10,
    SEL_ZERO = 2'b11
  } sel_e;

  localparam int unsigned LOAD_W = 4;
  localparam int unsigned LD_A   = 0;
  localparam int unsigned LD_B   = 1;
  localparam int unsigned LD_OUT = 2;
  localparam int unsigned LD_PC  = 3;

endpackage

// File: rtl/td4_alu.sv
// Combinational operand mux and adder: {CO,SUM} = operand + IM, where the
// operand is A, B, IN or zero.
module td4_alu
  import td4_pkg::*;
#(
  parameter int unsigned DW = 4
) (
  input  logic [1:0]    SELECT,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic [DW-1:0] IN,
  input  logic [DW-1:0] IM,
  output logic [DW-1:0] SUM,
  output logic          CO
);

  logic [DW-1:0] operand_s;
  logic [DW:0]   total_s;

  // operand source selection; the zero source is what makes a plain jump
  always_comb begin
    operand_s = {DW{1'b0}};
    case (sel_e'(SELECT))
      SEL_A:    operand_s = A;
      SEL_B:    operand_s = B;
      SEL_IN:   operand_s = IN;
      SEL_ZERO: operand_s = {DW{1'b0}};
      default:  operand_s = {DW{1'b0}};
    endcase
  end

  assign total_s = {1'b0, operand_s} + {1'b0, IM};
  assign SUM     = total_s[DW-1:0];
  assign CO      = total_s[DW];

endmodule

// File: rtl/td4_exec.sv
// TD4 execution unit: A, B, OUT, PC and carry registers around one shared
// adder; every output comes straight from a flop.
module td4_exec
  import td4_pkg::*;
#(
  parameter int unsigned DW = 4,
  parameter int unsigned PW = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic [LOAD_W-1:0] LOAD,
  input  logic [1:0]        SELECT,
  input  logic [DW-1:0]     IM,
  input  logic [DW-1:0]     IN,
  output logic [DW-1:0]     OUT,
  output logic [PW-1:0]     PC,
  output logic              CF,
  output logic [DW-1:0]     A_Q,
  output logic [DW-1:0]     B_Q
);

  localparam int unsigned XW = (PW > DW) ? PW : DW;

  logic [DW-1:0] a_r;
  logic [DW-1:0] b_r;
  logic [DW-1:0] out_r;
  logic [PW-1:0] pc_r;
  logic          cf_r;

  logic [DW-1:0] sum_s;
  logic          co_s;
  logic [XW-1:0] sum_x_s;
  logic [PW-1:0] pc_next_s;

  td4_alu #(.DW(DW)) u_alu (
    .SELECT (SELECT),
    .A      (a_r),
    .B      (b_r),
    .IN     (IN),
    .IM     (IM),
    .SUM    (sum_s),
    .CO     (co_s)
  );

  // the jump target is the adder result, zero-extended or truncated to PC width
  assign sum_x_s = XW'(sum_s);

  // next fetch address: jump target when PC load is asserted, else increment
  always_comb begin
    pc_next_s = pc_r;
    if (LOAD[LD_PC] == 1'b0) begin
      pc_next_s = sum_x_s[PW-1:0];
    end else begin
      pc_next_s = pc_r + PW'(1'b1);
    end
  end

  // architectural state; nothing moves unless EN is high on the edge
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_r   <= {DW{1'b0}};
      b_r   <= {DW{1'b0}};
      out_r <= {DW{1'b0}};
      pc_r  <= {PW{1'b0}};
      cf_r  <= 1'b0;
    end else if (EN) begin
      if (LOAD[LD_A] == 1'b0) begin
        a_r <= sum_s;
      end
      if (LOAD[LD_B] == 1'b0) begin
        b_r <= sum_s;
      end
      if (LOAD[LD_OUT] == 1'b0) begin
        out_r <= sum_s;
      end
      pc_r <= pc_next_s;
      cf_r <= co_s;
    end
  end

  assign A_Q = a_r;
  assign B_Q = b_r;
  assign OUT = out_r;
  assign PC  = pc_r;
  assign CF  = cf_r;

endmodule

// File: tb/tb_td4_exec.sv
// Directed bench for td4_exec: the driver pushes hand-computed post-edge state
// into a scoreboard queue and a monitor compares it after each clock edge.
module tb_td4_exec;
  import td4_pkg::*;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic [3:0] LOAD;
  logic [1:0] SELECT;
  logic [3:0] IM;
  logic [3:0] IN;
  logic [3:0] OUT;
  logic [3:0] PC;
  logic       CF;
  logic [3:0] A_Q;
  logic [3:0] B_Q;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] o;
    logic [3:0] pc;
    logic       cf;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  td4_exec #(.DW(4), .PW(4)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .EN     (EN),
    .LOAD   (LOAD),
    .SELECT (SELECT),
    .IM     (IM),
    .IN     (IN),
    .OUT    (OUT),
    .PC     (PC),
    .CF     (CF),
    .A_Q    (A_Q),
    .B_Q    (B_Q)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // monitor: compare the state presented after every edge against the queue head
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({A_Q, B_Q, OUT, PC, CF} !== {e.a, e.b, e.o, e.pc, e.cf}) begin
          n_fail++;
          $display("FAIL %s: got A=%h B=%h OUT=%h PC=%h CF=%b, expected A=%h B=%h OUT=%h PC=%h CF=%b",
                   e.name, A_Q, B_Q, OUT, PC, CF, e.a, e.b, e.o, e.pc, e.cf);
        end
      end
    end
  end

  task automatic step(input logic en, input logic [3:0] ld, input logic [1:0] sel,
                      input logic [3:0] im, input logic [3:0] inp,
                      input logic [3:0] ea, input logic [3:0] eb, input logic [3:0] eo,
                      input logic [3:0] ep, input logic ec, input string nm);
    exp_t e;
    @(negedge CLK);
    EN = en; LOAD = ld; SELECT = sel; IM = im; IN = inp;
    e.a = ea; e.b = eb; e.o = eo; e.pc = ep; e.cf = ec; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string nm);
    n_checks++;
    if ({A_Q, B_Q, OUT, PC, CF} !== 17'd0) begin
      n_fail++;
      $display("FAIL %s: got A=%h B=%h OUT=%h PC=%h CF=%b, expected all zero",
               nm, A_Q, B_Q, OUT, PC, CF);
    end
  endtask

  initial begin
    bit c;
    RST_N = 1'b0; EN = 1'b0; LOAD = 4'hF; SELECT = 2'b00; IM = 4'h0; IN = 4'h0;
    #1;
    check_zero("reset_initial");
    @(negedge CLK);
    RST_N = 1'b1;

    // build PC=5, A=7, CF=1
    step(1'b1, 4'b1110, SEL_A,    4'h7, 4'h0, 4'h7, 4'h0, 4'h0, 4'h1, 1'b0, "add_a7");
    step(1'b1, 4'b1110, SEL_A,    4'hF, 4'h0, 4'h6, 4'h0, 4'h0, 4'h2, 1'b1, "add_aF_carry");
    step(1'b1, 4'b1110, SEL_A,    4'h1, 4'h0, 4'h7, 4'h0, 4'h0, 4'h3, 1'b0, "add_a1");
    step(1'b1, 4'b1101, SEL_ZERO, 4'h9, 4'h0, 4'h7, 4'h9, 4'h0, 4'h4, 1'b0, "mov_b9");
    step(1'b1, 4'b1111, SEL_B,    4'h8, 4'h0, 4'h7, 4'h9, 4'h0, 4'h5, 1'b1, "noload_carry");

    // reset pulse between edges, with an instruction pending
    @(negedge CLK);
    EN = 1'b1; LOAD = 4'b0000; SELECT = SEL_ZERO; IM = 4'hC;
    #2;
    RST_N = 1'b0;
    #1;
    check_zero("reset_async");
    @(posedge CLK);
    #1;
    check_zero("reset_abort");
    @(negedge CLK);
    EN = 1'b0;
    RST_N = 1'b1;

    // first edge after reset executes from PC=0
    step(1'b1, 4'b1110, SEL_ZERO, 4'hE, 4'h0, 4'hE, 4'h0, 4'h0, 4'h1, 1'b0, "mov_aE_pc0");
    step(1'b1, 4'b1111, SEL_ZERO, 4'h0, 4'h0, 4'hE, 4'h0, 4'h0, 4'h2, 1'b0, "nop");
    step(1'b1, 4'b1110, SEL_A,    4'h3, 4'h0, 4'h1, 4'h0, 4'h0, 4'h3, 1'b1, "add_a3_wrap");
    step(1'b1, 4'b1101, SEL_IN,   4'h0, 4'h9, 4'h1, 4'h9, 4'h0, 4'h4, 1'b0, "in_b");
    step(1'b1, 4'b1011, SEL_B,    4'h1, 4'h0, 4'h1, 4'h9, 4'hA, 4'h5, 1'b0, "out_b1");
    step(1'b1, 4'b1111, SEL_B,    4'hF, 4'h0, 4'h1, 4'h9, 4'hA, 4'h6, 1'b1, "set_cf");
    step(1'b1, 4'b0111, SEL_ZERO, 4'h4, 4'h0, 4'h1, 4'h9, 4'hA, 4'h4, 1'b0, "jmp4_clr_cf");
    step(1'b1, 4'b0111, SEL_ZERO, 4'hA, 4'h0, 4'h1, 4'h9, 4'hA, 4'hA, 1'b0, "jmpA");
    step(1'b1, 4'b0111, SEL_ZERO, 4'hF, 4'h0, 4'h1, 4'h9, 4'hA, 4'hF, 1'b0, "jmpF");
    step(1'b1, 4'b1111, SEL_B,    4'hF, 4'h0, 4'h1, 4'h9, 4'hA, 4'h0, 1'b1, "pc_wrap");

    // hold with EN=0, including unknown controls
    step(1'b0, 4'b0000, SEL_IN,   4'h0, 4'hF, 4'h1, 4'h9, 4'hA, 4'h0, 1'b1, "hold0");
    step(1'b0, 4'b0000, SEL_IN,   4'h5, 4'hF, 4'h1, 4'h9, 4'hA, 4'h0, 1'b1, "hold1");
    step(1'b0, 4'bxxxx, 2'bxx,    4'h3, 4'hF, 4'h1, 4'h9, 4'hA, 4'h0, 1'b1, "hold_x");

    // several loads at once, then back-to-back use of a fresh A
    step(1'b1, 4'b1000, SEL_IN,   4'h2, 4'h5, 4'h7, 4'h7, 4'h7, 4'h1, 1'b0, "multi_load");
    step(1'b1, 4'b1110, SEL_A,    4'h1, 4'h0, 4'h8, 4'h7, 4'h7, 4'h2, 1'b0, "chain1");
    step(1'b1, 4'b1110, SEL_A,    4'h1, 4'h0, 4'h9, 4'h7, 4'h7, 4'h3, 1'b0, "chain2");
    step(1'b1, 4'b0110, SEL_ZERO, 4'h0, 4'h0, 4'h0, 4'h7, 4'h7, 4'h0, 1'b0, "clr_a_jmp0");

    // program "ADD A,1; JNC 0" decoded here; the loop exits once A wraps
    for (int i = 1; i <= 16; i++) begin
      c = (i == 16);
      step(1'b1, 4'b1110, SEL_A, 4'h1, 4'h0, 4'(i), 4'h7, 4'h7, 4'h1, c, "loop_add");
      if (!c) begin
        step(1'b1, 4'b0111, SEL_ZERO, 4'h0, 4'h0, 4'(i), 4'h7, 4'h7, 4'h0, 1'b0, "loop_jnc_taken");
      end else begin
        step(1'b1, 4'b1111, SEL_ZERO, 4'h0, 4'h0, 4'h0, 4'h7, 4'h7, 4'h2, 1'b0, "loop_jnc_fall");
      end
    end

    @(negedge CLK);
    EN = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/td4_exec.md
TD4_EXEC -- requirements
Module: td4_exec

Interface
REQ-001 Parameter: DW, default 4, data width of A, B, OUT, IN, IM and the adder.
REQ-002 Parameter: PW, default 4, program counter width; PC addresses 2^PW instruction words.
REQ-003 Port: CLK  input  1  system clock; all state updates on the rising edge.
REQ-004 Port: RST_N  input  1  reset, asynchronous, active-low.
REQ-005 Port: EN  input  1  execute strobe; the instruction on LOAD/SELECT/IM retires on a rising CLK edge with EN=1.
REQ-006 Port: LOAD  input  4  active-low load enables from the decoder: bit0 A, bit1 B, bit2 OUT, bit3 PC.
REQ-007 Port: SELECT  input  2  adder operand source: 00 A, 01 B, 10 IN, 11 zero.
REQ-008 Port: IM  input  DW  immediate field of the current instruction.
REQ-009 Port: IN  input  DW  external input port.
REQ-010 Port: OUT  output  DW  output port register.
REQ-011 Port: PC  output  PW  program counter, the fetch address for the instruction ROM.
REQ-012 Port: CF  output  1  registered carry flag, fed back to the decoder.
REQ-013 Port: A_Q, B_Q  output  DW each  current A and B register values, for debug and observation.

Function
REQ-014 The operand mux SHALL be combinational, selecting A, B, IN or zero per SELECT.
REQ-015 SUM and CO SHALL be {CO,SUM} = operand + IM, computed at DW+1 bits; SUM wraps modulo 2^DW.
REQ-016 On an EN edge, each register whose LOAD bit is 0 SHALL capture SUM[DW-1:0].
- Registers covered: A, B and OUT from LOAD bits 0-2.
- Each bit acts independently, so several bits low load the same SUM together.
REQ-017 On an EN edge with LOAD[3]=0, PC SHALL take SUM[PW-1:0]; with LOAD[3]=1, PC SHALL take PC+1, wrapping 2^PW-1 to 0.
REQ-018 On every EN edge, CF SHALL take CO, regardless of LOAD. A jump (zero+IM) therefore clears CF.
REQ-019 On an edge with EN=0, all state (A, B, OUT, PC, CF) SHALL hold.
REQ-020 Latency: a value written on edge N SHALL be visible on outputs after edge N and usable as an operand in cycle N+1. There is no bypass within a cycle.
REQ-021 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.
REQ-022 X or unknown on LOAD/SELECT while EN=0 SHALL NOT affect state.

Reset
REQ-023 While RST_N=0, A, B, OUT, PC and CF SHALL be 0, asynchronously and independent of CLK and EN.
REQ-024 Reset asserted mid-instruction SHALL abort that instruction with no partial update.
REQ-025 The first EN edge after RST_N rises SHALL execute with PC=0.

Structure
REQ-026 A shared package td4_pkg SHALL hold the following, for use by the decoder, td4_exec and the bench:
- SELECT codes: SEL_A=2'b00, SEL_B=2'b01, SEL_IN=2'b10, SEL_ZERO=2'b11.
- LOAD bit indices: LD_A=0, LD_B=1, LD_OUT=2, LD_PC=3.
REQ-027 The operand mux and adder SHALL be a combinational sub-module td4_alu with ports SELECT, A, B, IN, IM, SUM, CO.
REQ-028 td4_exec SHALL instantiate td4_alu once and contain only the registers and the PC incrementer.

Verification
REQ-029 Reset: run to PC=0x5, A=0x7, CF=1; pulse RST_N low between edges -> all outputs read 0 before the next CLK edge.
REQ-030 ADD A,IM: A=0xE, SELECT=00, LOAD=1110, IM=0x3, EN=1, PC=0x2 -> A=0x1, CF=1, PC=0x3, B and OUT unchanged.
REQ-031 IN B: IN=0x9, SELECT=10, LOAD=1101, IM=0x0 -> B=0x9, CF=0; OUT port: SELECT=01, LOAD=1011, IM=0x1 -> OUT=0xA.
REQ-032 JMP: PC=0x4, SELECT=11, LOAD=0111, IM=0xA -> PC=0xA, CF=0; then PC=0xF, LOAD=1111 -> PC=0x0.
REQ-033 Hold: EN=0 for 3 edges with LOAD=0000, SELECT=10, IN=0xF -> A, B, OUT, PC and CF are all unchanged.
REQ-034 JNC loop: the decoder and td4_exec together run the program "ADD A,1; JNC 0" from A=0 -> PC alternates 0,1 until A wraps 0xF->0x0 with CF=1, then PC reaches 0x2.
